brush_writer: RTL and testbench
===============================

# brush_writer

Paint-stroke writer feeding the scaled frame BRAM that the VGA output mux reads. For each accepted pen sample it writes a square brush of drawn-pixel bytes (type bits 2'b11 plus a 6-bit color code) into the 320x240 buffer, clipping at the frame edges. On request it sweeps the entire buffer to 8'h00. It sits between the pen tracker and BRAM port A; the display side reads port B.

## Interface
Parameters:
- H_RES, 320, buffer width in pixels
- V_RES, 240, buffer height in pixels
- BRUSH_R, 2, brush radius; brush side is 2*BRUSH_R+1
- ADDR_W, 17, BRAM address width; must hold H_RES*V_RES-1

Ports:
- clk_in  input  1  system clock; all logic on the rising edge
- rst_n_in  input  1  synchronous, active-low reset
- pen_x_in  input  9  pen column, unsigned
- pen_y_in  input  8  pen row, unsigned
- pen_color_in  input  2  0=blue, 1=yellow, 2=magenta, 3=no-op
- pen_valid_in  input  1  pen sample valid
- pen_ready_out  output  1  block can accept a pen sample
- clear_in  input  1  single-cycle request to erase the buffer
- busy_out  output  1  PAINT or CLEAR in progress
- bram_addr_out  output  ADDR_W  write address
- bram_data_out  output  8  write data
- bram_we_out  output  1  write enable

## Operation
- States: IDLE, PAINT, CLEAR.
- Reset values: state IDLE, bram_we_out 0, bram_addr_out 0, bram_data_out 0, busy_out 0, clear-pending 0. pen_ready_out is 1 on the first cycle after reset.
- pen_ready_out = (state==IDLE) && !clear-pending && !clear_in.
- In IDLE, clear_in wins over a simultaneous pen_valid_in: go to CLEAR and accept no pen sample.
- Pen accepted on a cycle with pen_valid_in && pen_ready_out. x, y and color are latched, and the state moves to PAINT.
- Color byte is {2'b11, code}. Codes: blue 6'b000000, yellow 6'b101010, magenta 6'b111111.
- Color 3 is still accepted and still runs the full PAINT sweep, but bram_we_out stays 0 throughout.
- PAINT visits offsets dy = -R..+R (outer loop) and dx = -R..+R (inner loop) in row-major order, one offset per cycle.
- Target coordinates are computed as signed 11-bit values: tx = x+dx, ty = y+dy.
- If tx<0, tx>=H_RES, ty<0 or ty>=V_RES, the write is suppressed (we=0) but the cycle is still spent. PAINT therefore always lasts (2R+1)^2 cycles.
- Address = ty*H_RES + tx, truncated to ADDR_W bits.
- CLEAR writes 8'h00 to addresses 0 through H_RES*V_RES-1 in ascending order, one per cycle.
- clear_in during PAINT: sets clear-pending. When PAINT finishes, the block goes straight to CLEAR with no IDLE cycle.
- clear_in during CLEAR: ignored; the sweep does not restart.
- pen_valid_in while not ready: ignored. The upstream block holds the sample until it is accepted.
- Reset asserted mid-PAINT or mid-CLEAR: at the next edge all outputs take their reset values, the sweep is abandoned, and no further writes occur.

## Timing
- All BRAM outputs are registered.
- Pen accepted at edge k:
  - first write (dx=dy=-R) appears on the outputs after edge k+1;
  - last write appears after edge k+(2R+1)^2;
  - bram_we_out is 0 and pen_ready_out is 1 after the following edge.
- busy_out is 1 from the edge after acceptance up to and including the last-write cycle.
- Throughput: one brush per (2R+1)^2+1 cycles (26 cycles for R=2).
- Clear: after entry, the write to address 0 appears the following cycle. Address H_RES*V_RES-1 appears 76800 cycles later for the defaults; bram_we_out is 0 the next cycle.
- bram_we_out is never 1 in IDLE.
- bram_addr_out and bram_data_out are don't-care when bram_we_out=0 but must never hold X after reset.

## Test plan
- Centre brush: pen (100,50), magenta, R=2 -> 25 writes of 8'hFF, in order:
  - addresses 48*320+98 through 48*320+102, then continuing down to row 52;
  - first write at cycle k+1; pen_ready_out high again at k+26.
- Corner clip: pen (0,0), yellow -> exactly 9 writes of 8'hEA, to addresses {0,1,2,320,321,322,640,641,642}. Still 25 busy cycles.
- Far corner: pen (319,239), blue -> 9 writes of 8'hC0. Maximum address 76799; no address >= 76800 is ever written.
- Color 3 with a simultaneous clear: pen (10,10) color 3, then clear_in pulsed on the 5th PAINT cycle ->
  - no writes during PAINT;
  - CLEAR starts immediately after PAINT;
  - 76800 writes of 8'h00 to addresses 0..76799, then IDLE.
- Priority: clear_in and pen_valid_in asserted together in IDLE -> CLEAR entered, pen not accepted (pen_ready_out 0 that cycle). The pen sample is accepted only after the clear completes.
- Reset mid-CLEAR: rst_n_in low at clear address 1000 -> next cycle bram_we_out=0 and busy_out=0. After release: pen_ready_out=1 and no residual writes.

Source files
------------

// File: rtl/brush_writer.sv
// Paints square pen brushes into the 320x240 scaled frame BRAM (port A) and
// sweeps the whole buffer to zero on request; clips brush pixels at the frame edges.
module brush_writer #(
    parameter int H_RES   = 320,
    parameter int V_RES   = 240,
    parameter int BRUSH_R = 2,
    parameter int ADDR_W  = 17
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [8:0]        pen_x_in,
    input  logic [7:0]        pen_y_in,
    input  logic [1:0]        pen_color_in,
    input  logic              pen_valid_in,
    output logic              pen_ready_out,
    input  logic              clear_in,
    output logic              busy_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [7:0]        bram_data_out,
    output logic              bram_we_out
);

    localparam int SIDE  = 2 * BRUSH_R + 1;
    localparam int OFS_W = $clog2(SIDE + 1);
    localparam logic [OFS_W-1:0]  OFS_LAST  = OFS_W'(SIDE - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PAINT = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t            r_state;
    logic [8:0]        r_x;
    logic [7:0]        r_y;
    logic [1:0]        r_color;
    logic [OFS_W-1:0]  r_dx;
    logic [OFS_W-1:0]  r_dy;
    logic              r_clr_pend;
    logic [ADDR_W-1:0] r_clr_addr;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic              r_busy;

    logic              w_pen_ready;
    logic [10:0]       w_tx;
    logic [10:0]       w_ty;
    logic              w_in_frame;
    logic [ADDR_W-1:0] w_paint_addr;
    logic [5:0]        w_code;
    logic              w_last_ofs;

    assign w_pen_ready = (r_state == S_IDLE) && !r_clr_pend && !clear_in;

    // Offsets count 0..2R, so subtracting R yields the signed dx/dy in two's complement.
    assign w_tx = 11'(r_x) + 11'(r_dx) - 11'(BRUSH_R);
    assign w_ty = 11'(r_y) + 11'(r_dy) - 11'(BRUSH_R);

    assign w_in_frame = !w_tx[10] && !w_ty[10]
                        && (w_tx < 11'(H_RES)) && (w_ty < 11'(V_RES));

    assign w_paint_addr = ADDR_W'(32'(w_ty) * 32'(H_RES) + 32'(w_tx));
    assign w_last_ofs   = (r_dx == OFS_LAST) && (r_dy == OFS_LAST);

    always_comb begin
        w_code = 6'b000000;
        case (r_color)
            2'd0:    w_code = 6'b000000;
            2'd1:    w_code = 6'b101010;
            2'd2:    w_code = 6'b111111;
            default: w_code = 6'b000000;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_color    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_clr_pend <= 1'b0;
            r_clr_addr <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_busy <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (clear_in) begin
                        r_state    <= S_CLEAR;
                        r_clr_addr <= '0;
                    end else if (pen_valid_in && w_pen_ready) begin
                        r_x     <= pen_x_in;
                        r_y     <= pen_y_in;
                        r_color <= pen_color_in;
                        r_dx    <= '0;
                        r_dy    <= '0;
                        r_state <= S_PAINT;
                    end
                end
                S_PAINT: begin
                    r_busy <= 1'b1;
                    r_we   <= w_in_frame && (r_color != 2'd3);
                    r_addr <= w_paint_addr;
                    r_data <= {2'b11, w_code};
                    if (r_dx == OFS_LAST) begin
                        r_dx <= '0;
                        r_dy <= r_dy + OFS_W'(1);
                    end else begin
                        r_dx <= r_dx + OFS_W'(1);
                    end
                    if (clear_in) begin
                        r_clr_pend <= 1'b1;
                    end
                    // A clear seen on the final offset still chains straight into CLEAR.
                    if (w_last_ofs) begin
                        if (r_clr_pend || clear_in) begin
                            r_state    <= S_CLEAR;
                            r_clr_pend <= 1'b0;
                            r_clr_addr <= '0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_CLEAR: begin
                    r_busy <= 1'b1;
                    r_we   <= 1'b1;
                    r_addr <= r_clr_addr;
                    r_data <= 8'h00;
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pen_ready_out = w_pen_ready;
    assign busy_out      = r_busy;
    assign bram_addr_out = r_addr;
    assign bram_data_out = r_data;
    assign bram_we_out   = r_we;

endmodule

// File: tb/tb_brush_writer.sv
// Bench for brush_writer: directed corner cases plus random brushes, checked against
// a pixel-level image model and a per-cycle expected write stream.
module tb_brush_writer;

    localparam int H    = 320;
    localparam int V    = 240;
    localparam int R    = 2;
    localparam int AW   = 17;
    localparam int SIDE = 2 * R + 1;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [8:0]    pen_x = '0;
    logic [7:0]    pen_y = '0;
    logic [1:0]    pen_color = '0;
    logic          pen_valid = 1'b0;
    logic          clear = 1'b0;
    logic          pen_ready;
    logic          busy;
    logic [AW-1:0] addr;
    logic [7:0]    data;
    logic          we;

    int n_checks = 0;
    int n_errors = 0;
    int n_writes = 0;
    int n_oob    = 0;

    logic [7:0] shadow  [NPIX];
    logic [7:0] exp_mem [NPIX];

    brush_writer #(.H_RES(H), .V_RES(V), .BRUSH_R(R), .ADDR_W(AW)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .pen_x_in      (pen_x),
        .pen_y_in      (pen_y),
        .pen_color_in  (pen_color),
        .pen_valid_in  (pen_valid),
        .pen_ready_out (pen_ready),
        .clear_in      (clear),
        .busy_out      (busy),
        .bram_addr_out (addr),
        .bram_data_out (data),
        .bram_we_out   (we)
    );

    always #5 clk = ~clk;

    // BRAM stand-in: capture every write on the falling edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            n_writes++;
            if (addr >= AW'(NPIX)) n_oob++;
            else shadow[addr] = data;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] color_byte(input int c);
        case (c)
            0:       return 8'hC0;
            1:       return 8'hEA;
            2:       return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    task automatic clear_sweep(input string name);
        int bad = 0;
        int w0  = n_writes;
        for (int j = 0; j < NPIX; j++) begin
            tick();
            if (!(we === 1'b1 && addr === AW'(j) && data === 8'h00 && busy === 1'b1))
                bad++;
            if (j < NPIX - 1 && pen_ready !== 1'b0) bad++;
            exp_mem[j] = 8'h00;
        end
        check_eq({name, "_clr_bad_cycles"}, bad, 0);
        tick();
        check_eq({name, "_clr_writes"}, n_writes - w0, NPIX);
        check_eq({name, "_clr_end_we"}, we, 0);
        check_eq({name, "_clr_end_busy"}, busy, 0);
        check_eq({name, "_clr_end_ready"}, pen_ready, 1);
        $display("clear  %s writes=%0d bad_cycles=%0d", name, n_writes - w0, bad);
    endtask

    // Presents one pen sample and checks the full 25-cycle write stream that follows.
    // clr_i >= 0 pulses clear_in on PAINT cycle clr_i+2 and then checks the chained sweep.
    task automatic paint(input int x, input int y, input int c, input int clr_i, input string name);
        int waited = 0;
        int nwr = 0;
        int w0;
        int tx, ty;
        logic exp_we;
        while (pen_ready !== 1'b1 && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) begin
            check_eq({name, "_ready_timeout"}, 0, 1);
            return;
        end
        w0 = n_writes;
        pen_x = 9'(x);
        pen_y = 8'(y);
        pen_color = 2'(c);
        pen_valid = 1'b1;
        tick();
        pen_valid = 1'b0;
        for (int i = 0; i < SIDE * SIDE; i++) begin
            tick();
            clear = (i == clr_i);
            ty = y + i / SIDE - R;
            tx = x + i % SIDE - R;
            exp_we = (tx >= 0) && (tx < H) && (ty >= 0) && (ty < V) && (c != 3);
            check_eq({name, "_we"}, we, exp_we);
            if (exp_we) begin
                check_eq({name, "_addr"}, addr, ty * H + tx);
                check_eq({name, "_data"}, data, color_byte(c));
                exp_mem[ty * H + tx] = color_byte(c);
                nwr++;
            end
            check_eq({name, "_busy"}, busy, 1);
            if (i < SIDE * SIDE - 1) check_eq({name, "_ready_low"}, pen_ready, 0);
        end
        clear = 1'b0;
        if (clr_i < 0) begin
            tick();
            check_eq({name, "_end_we"}, we, 0);
            check_eq({name, "_end_busy"}, busy, 0);
            check_eq({name, "_end_ready"}, pen_ready, 1);
            check_eq({name, "_nwrites"}, n_writes - w0, nwr);
        end
        $display("brush  %s x=%0d y=%0d color=%0d writes=%0d", name, x, y, c, n_writes - w0);
        if (clr_i >= 0) clear_sweep(name);
    endtask

    initial begin
        int diffs;
        int bad;
        int wc;
        for (int i = 0; i < NPIX; i++) begin
            shadow[i]  = 8'h00;
            exp_mem[i] = 8'h00;
        end

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_we", we, 0);
        check_eq("rst_addr", addr, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", pen_ready, 1);

        paint(100, 50, 2, -1, "centre");
        paint(0, 0, 1, -1, "corner");
        paint(319, 239, 0, -1, "far");
        paint(10, 10, 3, 3, "nop_clear");

        for (int n = 0; n < 30; n++)
            paint(int'($urandom_range(0, 330)), int'($urandom_range(0, 250)),
                  int'($urandom_range(0, 3)), -1, "rand");

        diffs = 0;
        for (int i = 0; i < NPIX; i++)
            if (shadow[i] !== exp_mem[i]) diffs++;
        check_eq("image_diff", diffs, 0);
        check_eq("oob_writes", n_oob, 0);

        // clear_in beats a simultaneous pen sample; the pen is held while clearing.
        pen_x = 9'd50;
        pen_y = 8'd60;
        pen_color = 2'd0;
        pen_valid = 1'b1;
        clear = 1'b1;
        #1;
        check_eq("prio_ready", pen_ready, 0);
        tick();
        clear = 1'b0;
        bad = 0;
        for (int j = 0; j <= 1000; j++) begin
            tick();
            if (!(we === 1'b1 && addr === AW'(j) && data === 8'h00 && pen_ready === 1'b0))
                bad++;
        end
        check_eq("prio_clear_bad_cycles", bad, 0);
        $display("clear  prio reached addr=%0d bad_cycles=%0d", addr, bad);

        rst_n = 1'b0;
        tick();
        check_eq("midrst_we", we, 0);
        check_eq("midrst_busy", busy, 0);
        pen_valid = 1'b0;
        rst_n = 1'b1;
        wc = n_writes;
        for (int j = 0; j < 5; j++) begin
            tick();
            check_eq("postrst_we", we, 0);
            check_eq("postrst_ready", pen_ready, 1);
        end
        check_eq("postrst_residual_writes", n_writes - wc, 0);
        $display("reset  mid-clear residual_writes=%0d", n_writes - wc);

        paint(50, 60, 0, -1, "held");
        check_eq("oob_writes_final", n_oob, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
